// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus width, stall patterns, stop levels and FSM state encodings
// for the pipeline stall controller.
package pipe_stall_ctrl_pkg;

  localparam int StallBus = 6;

  typedef logic [StallBus-1:0] stall_t;

  // Bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
  localparam stall_t STALL_NONE = 6'b000000;
  localparam stall_t STALL_LU   = 6'b000111;
  localparam stall_t STALL_MD   = 6'b001111;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline-to-stall-controller bundle: hazard requests and SRAM word in,
// stall bus and ID replay word out.
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic        stallreq_id;
  logic        stallreq_ex;
  logic        md_ready;
  logic [31:0] inst_sram_rdata;
  stall_t      stall;
  logic [31:0] inst_hold;
  logic        inst_hold_valid;
  logic        md_busy;

  modport master (
    output stallreq_id, stallreq_ex, md_ready, inst_sram_rdata,
    input  stall, inst_hold, inst_hold_valid, md_busy
  );

  modport slave (
    input  stallreq_id, stallreq_ex, md_ready, inst_sram_rdata,
    output stall, inst_hold, inst_hold_valid, md_busy
  );

endinterface

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// pipe_perf_cnt: 32-bit stall-cycle counter, counts while en is high and
// wraps from all-ones to zero; synchronous active-high reset.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (en) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles, multi-cycle mult/div wait and
// ID instruction replay capture. Optional stall counters under PIPE_PERF_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]       perf_lu_cnt,
  output logic [31:0]       perf_md_cnt
`endif
);

  state_t      state;
  stall_t      stall_c;
  logic        lu_cycle;
  logic [31:0] hold_q;
  logic        hold_valid_q;

  // Stall is combinational so a hazard freezes the front end in the same cycle.
  always_comb begin
    stall_c  = STALL_NONE;
    lu_cycle = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (bus.stallreq_ex) begin
            stall_c = STALL_MD;
          end else if (bus.stallreq_id) begin
            stall_c  = STALL_LU;
            lu_cycle = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          if (!bus.md_ready) begin
            stall_c = STALL_MD;
          end
        end
        default: begin
          stall_c = STALL_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.stallreq_ex) begin
            state <= ST_MD_WAIT;
          end
        end
        ST_MD_WAIT: begin
          if (bus.md_ready) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Only the first word seen while IF/ID is held is genuine; later SRAM
  // returns during the same hold are for a PC that has not advanced.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= 32'd0;
      hold_valid_q <= 1'b0;
    end else if (stall_c[1] == Stop) begin
      if (!hold_valid_q) begin
        hold_q       <= bus.inst_sram_rdata;
        hold_valid_q <= 1'b1;
      end
    end else begin
      hold_valid_q <= 1'b0;
    end
  end

  assign bus.stall           = stall_c;
  assign bus.inst_hold       = hold_q;
  assign bus.inst_hold_valid = hold_valid_q;
  assign bus.md_busy         = !rst && (state == ST_MD_WAIT);

`ifdef PIPE_PERF_EN
  pipe_perf_cnt u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .en  (lu_cycle),
    .cnt (perf_lu_cnt)
  );

  pipe_perf_cnt u_md_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_c == STALL_MD),
    .cnt (perf_md_cnt)
  );
`else
  logic unused_lu;
  assign unused_lu = lu_cycle;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table plus hand sequences for divide,
// reset during MD_WAIT and counter wrap (counter checks need PIPE_PERF_EN).
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

`ifdef PIPE_PERF_EN
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_md_cnt;
`endif

  pipe_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef PIPE_PERF_EN
    ,
    .perf_lu_cnt (perf_lu_cnt),
    .perf_md_cnt (perf_md_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        id;
    logic        ex;
    logic        rdy;
    logic [31:0] rdata;
    logic [5:0]  e_stall;
    logic        e_busy;
    logic        e_hv;
    logic        chk_hold;
    logic [31:0] e_hold;
  } vec_t;

  typedef struct {
    logic [5:0]  stall;
    logic        busy;
    logic        hv;
    logic        chk_hold;
    logic [31:0] hold;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[15];

  function automatic vec_t mk(logic r, logic id, logic ex, logic rdy, logic [31:0] rd,
                              logic [5:0] es, logic eb, logic ehv, logic ch, logic [31:0] eh);
    vec_t v;
    v.rst = r; v.id = id; v.ex = ex; v.rdy = rdy; v.rdata = rd;
    v.e_stall = es; v.e_busy = eb; v.e_hv = ehv; v.chk_hold = ch; v.e_hold = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, record expectations, sample before the rising edge.
  task automatic run_cycle(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    rst                 = v.rst;
    bus.stallreq_id     = v.id;
    bus.stallreq_ex     = v.ex;
    bus.md_ready        = v.rdy;
    bus.inst_sram_rdata = v.rdata;
    e.stall = v.e_stall; e.busy = v.e_busy; e.hv = v.e_hv;
    e.chk_hold = v.chk_hold; e.hold = v.e_hold;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check({name, ".stall"}, {26'd0, bus.stall}, {26'd0, e.stall});
    check({name, ".md_busy"}, {31'd0, bus.md_busy}, {31'd0, e.busy});
    check({name, ".hold_valid"}, {31'd0, bus.inst_hold_valid}, {31'd0, e.hv});
    if (e.chk_hold) check({name, ".inst_hold"}, bus.inst_hold, e.hold);
  endtask

  initial begin
    int md_cycles;
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.md_ready = 1'b0;
    bus.inst_sram_rdata = 32'd0;
    repeat (2) @(posedge clk);

    //           rst id ex rdy rdata          stall      busy hv chk hold
    vecs[0]  = mk(1, 1, 1, 0, 32'h0BAD0BAD, STALL_NONE, 0, 0, 1, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h11111111, STALL_NONE, 0, 0, 1, 32'h0);
    vecs[2]  = mk(0, 1, 0, 0, 32'h8C820000, STALL_LU,   0, 0, 1, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 32'hDEADBEEF, STALL_NONE, 0, 1, 1, 32'h8C820000);
    vecs[4]  = mk(0, 0, 0, 0, 32'hDEADBEEF, STALL_NONE, 0, 0, 1, 32'h8C820000);
    vecs[5]  = mk(0, 0, 0, 1, 32'h22222222, STALL_NONE, 0, 0, 1, 32'h8C820000);
    vecs[6]  = mk(0, 1, 0, 0, 32'h000000A1, STALL_LU,   0, 0, 0, 32'h0);
    vecs[7]  = mk(0, 1, 0, 0, 32'h000000A2, STALL_LU,   0, 1, 1, 32'h000000A1);
    vecs[8]  = mk(0, 0, 0, 0, 32'h000000A3, STALL_NONE, 0, 1, 1, 32'h000000A1);
    vecs[9]  = mk(0, 0, 0, 0, 32'h000000A4, STALL_NONE, 0, 0, 1, 32'h000000A1);
    vecs[10] = mk(0, 1, 1, 0, 32'h000000B0, STALL_MD,   0, 0, 0, 32'h0);
    vecs[11] = mk(0, 1, 0, 0, 32'h000000B1, STALL_MD,   1, 1, 1, 32'h000000B0);
    vecs[12] = mk(0, 0, 1, 0, 32'h000000B2, STALL_MD,   1, 1, 1, 32'h000000B0);
    vecs[13] = mk(0, 0, 0, 1, 32'h000000B3, STALL_NONE, 1, 1, 1, 32'h000000B0);
    vecs[14] = mk(0, 0, 0, 0, 32'h000000B4, STALL_NONE, 0, 0, 1, 32'h000000B0);

    for (int i = 0; i < 15; i++) begin
      run_cycle(vecs[i], $sformatf("vec%0d", i));
    end
`ifdef PIPE_PERF_EN
    check("table.perf_lu_cnt", perf_lu_cnt, 32'd3);
    check("table.perf_md_cnt", perf_md_cnt, 32'd3);
`endif

    // Divide: one start cycle, 32 waiting cycles, then md_ready.
    md_cycles = 0;
    run_cycle(mk(0, 0, 1, 0, 32'h1, STALL_MD, 0, 0, 0, 32'h0), "div.start");
    if (bus.stall == STALL_MD) md_cycles++;
    for (int i = 0; i < 32; i++) begin
      run_cycle(mk(0, 0, 0, 0, 32'h2, STALL_MD, 1, 1, 1, 32'h1), $sformatf("div.wait%0d", i));
      if (bus.stall == STALL_MD) md_cycles++;
    end
    run_cycle(mk(0, 0, 0, 1, 32'h3, STALL_NONE, 1, 1, 1, 32'h1), "div.done");
    run_cycle(mk(0, 0, 0, 0, 32'h4, STALL_NONE, 0, 0, 1, 32'h1), "div.after");
    check("div.md_stall_cycles", md_cycles, 33);
`ifdef PIPE_PERF_EN
    check("div.perf_md_cnt", perf_md_cnt, 32'd36);
    check("div.perf_lu_cnt", perf_lu_cnt, 32'd3);
`endif

    // Reset on the 5th MD_WAIT cycle abandons the wait.
    run_cycle(mk(0, 0, 1, 0, 32'h5, STALL_MD, 0, 0, 0, 32'h0), "rstmd.start");
    for (int i = 0; i < 4; i++) begin
      run_cycle(mk(0, 0, 0, 0, 32'h6, STALL_NONE | STALL_MD, 1, 1, 1, 32'h5),
                $sformatf("rstmd.wait%0d", i));
    end
    run_cycle(mk(1, 1, 1, 0, 32'h7, STALL_NONE, 0, 1, 1, 32'h5), "rstmd.rst");
    run_cycle(mk(0, 0, 0, 0, 32'h8, STALL_NONE, 0, 0, 1, 32'h0), "rstmd.after");
    run_cycle(mk(0, 0, 0, 0, 32'h9, STALL_NONE, 0, 0, 1, 32'h0), "rstmd.idle");
`ifdef PIPE_PERF_EN
    check("rstmd.perf_lu_cnt", perf_lu_cnt, 32'd0);
    check("rstmd.perf_md_cnt", perf_md_cnt, 32'd0);

    // Counter wrap from all-ones on a single load-use cycle.
    @(negedge clk);
    force dut.u_lu_cnt.cnt = 32'hFFFFFFFF;
    #1;
    release dut.u_lu_cnt.cnt;
    run_cycle(mk(0, 1, 0, 0, 32'hC0DE0000, STALL_LU, 0, 0, 0, 32'h0), "wrap.lu");
    run_cycle(mk(0, 0, 0, 0, 32'h0, STALL_NONE, 0, 1, 1, 32'hC0DE0000), "wrap.after");
    check("wrap.perf_lu_cnt", perf_lu_cnt, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 stallreq_id  input  1  load-use hazard request from ID; combinational, same cycle.
REQ-004 stallreq_ex  input  1  multi-cycle mult/div start request from EX; pulse or level.
REQ-005 md_ready  input  1  mult/div unit result valid this cycle.
REQ-006 inst_sram_rdata  input  32  instruction word currently returned by instruction SRAM.
REQ-007 stall  output  6  stall bus: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = hold.
REQ-008 inst_hold  output  32  captured instruction for ID replay.
REQ-009 inst_hold_valid  output  1  ID uses inst_hold instead of inst_sram_rdata.
REQ-010 md_busy  output  1  high while in MD_WAIT.
REQ-011 perf_lu_cnt, perf_md_cnt  output  32 each  stall-cycle counters; present only with PIPE_PERF_EN.

Function
REQ-012 FSM states: RUN, MD_WAIT; stall is combinational from state and requests.
REQ-013 RUN, stallreq_ex=1: stall=6'b001111 same cycle; next state MD_WAIT.
REQ-014 RUN, stallreq_id=1, stallreq_ex=0: stall=6'b000111 for that cycle only (bubble into EX); state stays RUN.
REQ-015 RUN, no request: stall=6'b000000.
REQ-016 MD_WAIT, md_ready=0: stall=6'b001111; md_busy=1.
REQ-017 MD_WAIT, md_ready=1: stall=6'b000000 that cycle; next state RUN.
REQ-018 stallreq_ex has priority over stallreq_id when both are asserted; stall is the EX pattern.
REQ-019 stallreq_id and stallreq_ex are ignored in MD_WAIT.
REQ-020 Any cycle with stall[1]=1 and inst_hold_valid=0: inst_hold <= inst_sram_rdata, inst_hold_valid <= 1.
REQ-021 stall[1]=1 and inst_hold_valid=1: inst_hold keeps its value (no re-capture from a stale SRAM word).
REQ-022 stall[1]=0: inst_hold_valid <= 0 at the next edge; inst_hold keeps its value.
REQ-023 Back-to-back load-use (stallreq_id high two consecutive cycles): each cycle gives stall=6'b000111; the instruction captured on the first cycle is retained.
REQ-024 md_ready asserted in RUN: ignored.

Reset
REQ-025 rst=1 at the edge: state=RUN, inst_hold=0, inst_hold_valid=0, counters=0.
REQ-026 During rst: stall=6'b000000 and md_busy=0 regardless of inputs.
REQ-027 Reset during MD_WAIT: abandons the wait with no further stall cycles.

Configuration
REQ-028 Macro PIPE_PERF_EN defined: perf_lu_cnt increments on each REQ-014 cycle; perf_md_cnt increments on each stall=6'b001111 cycle; both wrap at 2^32-1 -> 0.
REQ-029 PIPE_PERF_EN undefined: the perf ports and counters are absent; all other behaviour is identical.

Structure
REQ-030 Shared defines header holds StallBus=6, the stall patterns STALL_NONE/STALL_LU/STALL_MD, Stop/NoStop, and the FSM state encodings.
REQ-031 One sub-module, pipe_perf_cnt (a 32-bit wrapping counter with enable), is instantiated twice, only under PIPE_PERF_EN.
REQ-032 No other sub-modules.

Verification
REQ-033 Reset, idle: rst=1 then 0, no requests -> stall=0, inst_hold_valid=0, counters=0.
REQ-034 Load-use: stallreq_id=1 one cycle, inst_sram_rdata=32'h8C820000 -> stall=6'b000111 that cycle; next cycle inst_hold=32'h8C820000, inst_hold_valid=1, stall=0; following cycle inst_hold_valid=0.
REQ-035 Divide: stallreq_ex=1 one cycle, md_ready=1 after 32 cycles -> stall=6'b001111 for 33 cycles, then 0; perf_md_cnt=33 with PIPE_PERF_EN.
REQ-036 Simultaneous stallreq_id=1 and stallreq_ex=1 -> stall=6'b001111; state MD_WAIT; perf_lu_cnt unchanged.
REQ-037 rst=1 on the 5th cycle of MD_WAIT -> next cycle state RUN, stall=0, md_busy=0, inst_hold_valid=0.
REQ-038 Counter wrap: preload perf_lu_cnt to 32'hFFFFFFFF via force, one load-use cycle -> 0.
